// File: rtl/iq_split_fifo.sv
// N-lane stream splitter: one input beat carries CHANNELS samples, each routed
// into its own DEPTH-entry FIFO and drained by an independent consumer.
module iq_split_fifo #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [CHANNELS*WIDTH-1:0]              input_tdata,
  input  logic                                   input_tvalid,
  output logic                                   input_tready,
  input  logic [CHANNELS-1:0]                    lane_enable,
  output logic [CHANNELS*WIDTH-1:0]              output_tdata,
  output logic [CHANNELS-1:0]                    output_tvalid,
  input  logic [CHANNELS-1:0]                    output_tready,
  output logic [CHANNELS*($clog2(DEPTH)+1)-1:0]  output_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q   [CHANNELS][DEPTH];
  logic [WIDTH-1:0] mem_d   [CHANNELS][DEPTH];
  logic [PW-1:0]    wr_ptr_q [CHANNELS];
  logic [PW-1:0]    wr_ptr_d [CHANNELS];
  logic [PW-1:0]    rd_ptr_q [CHANNELS];
  logic [PW-1:0]    rd_ptr_d [CHANNELS];
  logic [CW-1:0]    count_q  [CHANNELS];
  logic [CW-1:0]    count_d  [CHANNELS];

  logic                accept;
  logic [CHANNELS-1:0] wr_en;
  logic [CHANNELS-1:0] rd_en;

  // Only enabled full lanes block the input; a same-cycle read never helps.
  always_comb begin
    input_tready = 1'b1;
    for (int k = 0; k < CHANNELS; k++) begin
      if (lane_enable[k] && (count_q[k] == CW'(DEPTH))) begin
        input_tready = 1'b0;
      end
    end
  end

  always_comb begin
    output_tdata  = '0;
    output_tvalid = '0;
    output_count  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      output_tdata[k*WIDTH +: WIDTH] = mem_q[k][rd_ptr_q[k]];
      output_tvalid[k]               = (count_q[k] != '0);
      output_count[k*CW +: CW]       = count_q[k];
    end
  end

  always_comb begin
    accept = input_tvalid & input_tready;
    wr_en  = '0;
    rd_en  = '0;
    mem_d  = mem_q;
    for (int k = 0; k < CHANNELS; k++) begin
      wr_en[k]    = accept & lane_enable[k];
      rd_en[k]    = output_tvalid[k] & output_tready[k];
      wr_ptr_d[k] = wr_ptr_q[k];
      rd_ptr_d[k] = rd_ptr_q[k];
      count_d[k]  = count_q[k];
      if (wr_en[k]) begin
        mem_d[k][wr_ptr_q[k]] = input_tdata[k*WIDTH +: WIDTH];
        wr_ptr_d[k]           = wr_ptr_q[k] + PW'(1);
      end
      if (rd_en[k]) begin
        rd_ptr_d[k] = rd_ptr_q[k] + PW'(1);
      end
      case ({wr_en[k], rd_en[k]})
        2'b10:   count_d[k] = count_q[k] + CW'(1);
        2'b01:   count_d[k] = count_q[k] - CW'(1);
        default: count_d[k] = count_q[k];
      endcase
      if (rst) begin
        wr_ptr_d[k] = '0;
        rd_ptr_d[k] = '0;
        count_d[k]  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < CHANNELS; k++) begin
      wr_ptr_q[k] <= wr_ptr_d[k];
      rd_ptr_q[k] <= rd_ptr_d[k];
      count_q[k]  <= count_d[k];
    end
  end

  // Sample storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_iq_split_fifo.sv
// Randomised and directed bench for iq_split_fifo against a queue-based
// per-lane model.
module tb_iq_split_fifo;

  localparam int WIDTH    = 16;
  localparam int CHANNELS = 4;
  localparam int DEPTH    = 4;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [CHANNELS*WIDTH-1:0]    input_tdata;
  logic                         input_tvalid;
  logic                         input_tready;
  logic [CHANNELS-1:0]          lane_enable;
  logic [CHANNELS*WIDTH-1:0]    output_tdata;
  logic [CHANNELS-1:0]          output_tvalid;
  logic [CHANNELS-1:0]          output_tready;
  logic [CHANNELS*CW-1:0]       output_count;

  logic [WIDTH-1:0] model_q [CHANNELS][$];
  int checkCount = 0;
  int errorCount = 0;
  int seq = 0;

  always #5 clk = ~clk;

  iq_split_fifo #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_tdata  (input_tdata),
    .input_tvalid (input_tvalid),
    .input_tready (input_tready),
    .lane_enable  (lane_enable),
    .output_tdata (output_tdata),
    .output_tvalid(output_tvalid),
    .output_tready(output_tready),
    .output_count (output_count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic modelReady();
    logic r = 1'b1;
    for (int k = 0; k < CHANNELS; k++)
      if (lane_enable[k] && model_q[k].size() == DEPTH) r = 1'b0;
    return r;
  endfunction

  task automatic compareAll();
    checkOutput("input_tready", 64'(input_tready), 64'(modelReady()));
    for (int k = 0; k < CHANNELS; k++) begin
      checkOutput($sformatf("tvalid[%0d]", k), 64'(output_tvalid[k]), 64'(model_q[k].size() != 0));
      checkOutput($sformatf("count[%0d]", k), 64'(output_count[k*CW +: CW]), 64'(model_q[k].size()));
      if (model_q[k].size() != 0)
        checkOutput($sformatf("tdata[%0d]", k), 64'(output_tdata[k*WIDTH +: WIDTH]), 64'(model_q[k][0]));
    end
  endtask

  // Called at a falling edge: drive, compare, step the model across one rising edge.
  task automatic applyStimulus(input logic v, input logic [CHANNELS*WIDTH-1:0] d,
                               input logic [CHANNELS-1:0] en, input logic [CHANNELS-1:0] rdy,
                               input logic r, output logic acc);
    logic [CHANNELS-1:0] rd;
    input_tvalid  = v;
    input_tdata   = d;
    lane_enable   = en;
    output_tready = rdy;
    rst           = r;
    #1;
    compareAll();
    acc = v & modelReady();
    for (int k = 0; k < CHANNELS; k++) rd[k] = (model_q[k].size() != 0) && rdy[k];
    @(posedge clk);
    for (int k = 0; k < CHANNELS; k++) begin
      if (r) model_q[k].delete();
      else begin
        if (rd[k]) void'(model_q[k].pop_front());
        if (acc && en[k]) model_q[k].push_back(d[k*WIDTH +: WIDTH]);
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [CHANNELS*WIDTH-1:0] nextBeat();
    logic [CHANNELS*WIDTH-1:0] b;
    seq++;
    for (int k = 0; k < CHANNELS; k++) b[k*WIDTH +: WIDTH] = WIDTH'((k << 12) | (seq & 12'hfff));
    return b;
  endfunction

  function automatic logic modelEmpty();
    logic e = 1'b1;
    for (int k = 0; k < CHANNELS; k++) if (model_q[k].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drainAll();
    logic acc;
    for (int i = 0; i < 4 * DEPTH && !modelEmpty(); i++)
      applyStimulus(1'b0, '0, '1, '1, 1'b0, acc);
  endtask

  initial begin : main
    logic acc;
    int beats;
    int cycles;
    logic [CHANNELS-1:0] en;

    rst = 1'b1; input_tvalid = 1'b0; input_tdata = '0;
    lane_enable = '1; output_tready = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_tvalid", 64'(output_tvalid), 64'h0);
    checkOutput("reset_count", 64'(output_count), 64'h0);
    checkOutput("reset_tready", 64'(input_tready), 64'h1);

    // Single beat, one-cycle latency
    applyStimulus(1'b1, 64'h0004_0003_0001_0002, '1, '1, 1'b0, acc);
    checkOutput("t1_out0", 64'(output_tdata[15:0]), 64'h0002);
    checkOutput("t1_out1", 64'(output_tdata[31:16]), 64'h0001);
    checkOutput("t1_tvalid", 64'(output_tvalid), 64'hf);
    checkOutput("t1_tready", 64'(input_tready), 64'h1);
    drainAll();

    // Lane 1 stalled: four beats fit, then the input blocks
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, nextBeat(), '1, 4'b1101, 1'b0, acc);
    checkOutput("t2_count1", 64'(output_count[CW +: CW]), 64'd4);
    checkOutput("t2_tready", 64'(input_tready), 64'h0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, nextBeat(), '1, 4'b1101, 1'b0, acc);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, nextBeat(), '1, '1, 1'b0, acc);
    drainAll();

    // Full lane read while input waits: no accept that cycle
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, nextBeat(), '1, 4'b1101, 1'b0, acc);
    input_tvalid = 1'b1; output_tready = '1; #1;
    checkOutput("t3_tready_full_read", 64'(input_tready), 64'h0);
    applyStimulus(1'b1, nextBeat(), '1, '1, 1'b0, acc);
    checkOutput("t3_count_after_read", 64'(output_count[CW +: CW]), 64'd3);
    applyStimulus(1'b1, nextBeat(), '1, 4'b1101, 1'b0, acc);
    checkOutput("t3_count_after_accept", 64'(output_count[CW +: CW]), 64'd4);

    // Lane 1 full and disabled: input keeps flowing
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, nextBeat(), 4'b1101, 4'b1101, 1'b0, acc);
    checkOutput("t4_count1", 64'(output_count[CW +: CW]), 64'd4);
    checkOutput("t4_tready_disabled", 64'(input_tready), 64'h1);
    lane_enable = '1; #1;
    checkOutput("t4_tready_reenabled", 64'(input_tready), 64'h0);
    drainAll();

    // Reset with data buffered
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, nextBeat(), '1, '0, 1'b0, acc);
    applyStimulus(1'b0, '0, '1, '0, 1'b1, acc);
    checkOutput("t5_tvalid", 64'(output_tvalid), 64'h0);
    checkOutput("t5_count", 64'(output_count), 64'h0);
    applyStimulus(1'b1, 64'h0d0d_0c0c_0b0b_0a0a, '1, '0, 1'b0, acc);
    checkOutput("t5_first_beat", 64'(output_tdata), 64'h0d0d_0c0c_0b0b_0a0a);
    drainAll();

    // All lanes disabled: beats discarded
    applyStimulus(1'b1, nextBeat(), '0, '1, 1'b0, acc);
    checkOutput("all_disabled_tvalid", 64'(output_tvalid), 64'h0);

    // Random traffic
    beats = 0; cycles = 0; en = '1;
    while (beats < 10000 && cycles < 60000) begin
      if ($urandom_range(0, 49) == 0) en = ($urandom_range(0, 3) == 0) ? CHANNELS'($urandom) : '1;
      for (int k = 0; k < CHANNELS; k++) output_tready[k] = ($urandom_range(0, 3) != 0);
      applyStimulus(($urandom_range(0, 4) != 0), CHANNELS*WIDTH'({$urandom, $urandom}), en,
                    output_tready, 1'b0, acc);
      if (acc) beats++;
      cycles++;
    end
    if (beats < 10000) checkOutput("random_beat_budget", 64'(beats), 64'd10000);
    drainAll();
    #1;
    checkOutput("final_count", 64'(output_count), 64'h0);
    checkOutput("final_tvalid", 64'(output_tvalid), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
